// File: rtl/mul_tc_pkg.sv
// ---------------------------------------------------------------------------
// mul_tc_pkg
// Shared definitions for the 16x16 two's-complement multiplier datapath
// (carry-save reduction and final carry-propagate stage).
//   PROD_W : product / redundant-vector width
//   LO_W   : width of the low-half adder in the CPA pipeline
//   prod_t : full product word
//   half_t : half-word handled by one 16-bit ripple adder
//   fa()   : full-adder cell, returns {carry, sum}
// ---------------------------------------------------------------------------
package mul_tc_pkg;

  localparam int PROD_W = 32;
  localparam int LO_W   = 16;
  localparam int HI_W   = PROD_W - LO_W;

  typedef logic [PROD_W-1:0] prod_t;
  typedef logic [LO_W-1:0]   half_t;

  // Full-adder cell: {carry_out, sum}
  function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
    fa = {(a & b) | (a & ci) | (b & ci), a ^ b ^ ci};
  endfunction

endpackage

// File: rtl/add_rca_16.sv
// ---------------------------------------------------------------------------
// add_rca_16
// 16-bit ripple-carry adder built from the shared full-adder cell.
// Ports:
//   a, b : addends (16 bits)
//   cin  : carry in
//   sum  : a + b + cin, low 16 bits
//   cout : carry out of bit 15
// ---------------------------------------------------------------------------
module add_rca_16
  import mul_tc_pkg::*;
(
  input  logic [LO_W-1:0] a,
  input  logic [LO_W-1:0] b,
  input  logic            cin,
  output logic [LO_W-1:0] sum,
  output logic            cout
);

  logic [LO_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < LO_W; i++) begin : g_bit
    assign {carry[i+1], sum[i]} = fa(a[i], b[i], carry[i]);
  end

  assign cout = carry[LO_W];

endmodule

// File: rtl/mul_cpa_pipe.sv
// ---------------------------------------------------------------------------
// mul_cpa_pipe
// Final carry-propagate stage of the 16x16 two's-complement multiplier.
// Resolves the last carry-save pair into product = s_in + (c_in << 1)
// mod 2^PROD_W through a two-stage pipeline split at bit LO_W.
// Stage 1 adds the low half and captures the high-half operands; stage 2
// adds the high half with the stage-1 carry and registers the product.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   in_valid   : s_in/c_in valid
//   in_ready   : block accepts this cycle (combinational, no bubble)
//   s_in       : CSA sum vector
//   c_in       : CSA carry vector, unshifted (bit i weighs 2^(i+1))
//   out_valid  : product valid
//   out_ready  : downstream accepts
//   product    : registered result, held while stalled
//   done_cnt   : (only with MUL_CPA_STATS_EN) saturating count of
//                completed output transfers
//
// Optional feature macro: MUL_CPA_STATS_EN
// ---------------------------------------------------------------------------
module mul_cpa_pipe
  import mul_tc_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PROD_W-1:0] s_in,
  input  logic [PROD_W-1:0] c_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
`ifdef MUL_CPA_STATS_EN
  ,
  output logic [15:0]       done_cnt
`endif
);

  // Pipeline state
  logic  v1;
  logic  v2;
  half_t lo_sum;
  logic  lo_cout;
  half_t hi_s;
  half_t hi_c;

  // Combinational datapath / handshake
  prod_t c_sh;
  half_t lo_sum_nxt;
  logic  lo_cout_nxt;
  half_t hi_sum_nxt;
  logic  unused_hi_cout;
  logic  unused_bits;
  logic  accept;
  logic  adv2;

  // The carry MSB falls off the top after the shift (mod 2^PROD_W).
  assign c_sh = {c_in[PROD_W-2:0], 1'b0};

  assign adv2     = v1 & (~v2 | out_ready);
  assign in_ready = ~v1 | adv2;
  assign accept   = in_valid & in_ready;
  assign out_valid = v2;

  // Discarded bits collected so they are visibly consumed.
  assign unused_bits = ^{c_in[PROD_W-1], unused_hi_cout};

  add_rca_16 u_add_lo (
    .a    (s_in[LO_W-1:0]),
    .b    (c_sh[LO_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum_nxt),
    .cout (lo_cout_nxt)
  );

  add_rca_16 u_add_hi (
    .a    (hi_s),
    .b    (hi_c),
    .cin  (lo_cout),
    .sum  (hi_sum_nxt),
    .cout (unused_hi_cout)
  );

  // Valid flags: a simultaneous accept and advance keeps v1 set with new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (accept) begin
        v1 <= 1'b1;
      end else if (adv2) begin
        v1 <= 1'b0;
      end else begin
        v1 <= v1;
      end

      if (adv2) begin
        v2 <= 1'b1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end else begin
        v2 <= v2;
      end
    end
  end

  // Stage-1 data: loads only on accept so idle inputs never toggle state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_sum  <= {LO_W{1'b0}};
      lo_cout <= 1'b0;
      hi_s    <= {LO_W{1'b0}};
      hi_c    <= {LO_W{1'b0}};
    end else if (accept) begin
      lo_sum  <= lo_sum_nxt;
      lo_cout <= lo_cout_nxt;
      hi_s    <= s_in[PROD_W-1:LO_W];
      hi_c    <= c_sh[PROD_W-1:LO_W];
    end else begin
      lo_sum  <= lo_sum;
      lo_cout <= lo_cout;
      hi_s    <= hi_s;
      hi_c    <= hi_c;
    end
  end

  // Stage-2 product register: holds value while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= {PROD_W{1'b0}};
    end else if (adv2) begin
      product <= {hi_sum_nxt, lo_sum};
    end else begin
      product <= product;
    end
  end

`ifdef MUL_CPA_STATS_EN
  // Completed-transfer counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= 16'h0000;
    end else if (v2 && out_ready && (done_cnt != 16'hFFFF)) begin
      done_cnt <= done_cnt + 16'h0001;
    end else begin
      done_cnt <= done_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_mul_cpa_pipe.sv
// ---------------------------------------------------------------------------
// tb_mul_cpa_pipe
// Directed, table-driven bench for mul_cpa_pipe: hand-computed s/c/product
// vectors, plus backpressure and mid-operation reset sequences.
// ---------------------------------------------------------------------------
module tb_mul_cpa_pipe;
  import mul_tc_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  in_valid;
  logic  in_ready;
  prod_t s_in;
  prod_t c_in;
  logic  out_valid;
  logic  out_ready;
  prod_t product;
`ifdef MUL_CPA_STATS_EN
  logic [15:0] done_cnt;
`endif

  always #5 clk = ~clk;

  mul_cpa_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s_in      (s_in),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
`ifdef MUL_CPA_STATS_EN
    ,
    .done_cnt  (done_cnt)
`endif
  );

  typedef struct {
    prod_t s;
    prod_t c;
    prod_t p;
  } vec_t;

  vec_t  vt[10];
  prod_t q[$];
  int    n_vec  = 0;
  int    n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transfer with out_ready=1: valid exactly 2 cycles after accept.
  task automatic apply_vec(input vec_t v, input string tag);
    @(posedge clk); #1;
    in_valid = 1'b1; s_in = v.s; c_in = v.c; out_ready = 1'b1;
    @(negedge clk);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; s_in = 32'h0; c_in = 32'h0;
    @(negedge clk);
    check({tag, " early valid"}, {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " product"}, product, v.p);
    @(negedge clk);
    check({tag, " drained"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int sent;
    int got;
    int first_out;
    int last_out;

    vt[0] = '{32'h0000_0003, 32'h0000_0002, 32'h0000_0007};
    vt[1] = '{32'h0000_FFFF, 32'h0000_0001, 32'h0001_0001};
    vt[2] = '{32'hFFFF_FFF0, 32'h0000_0008, 32'h0000_0000};
    vt[3] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000};
    vt[4] = '{32'hFFFE_FFF1, 32'h0000_8000, 32'hFFFF_FFF1}; // -3*5
    vt[5] = '{32'hBFFF_0000, 32'h0000_C000, 32'hC000_8000}; // 32767*-32768
    vt[6] = '{32'h1234_5678, 32'h1111_1111, 32'h3456_789A};
    vt[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[8] = '{32'h0000_8000, 32'h0000_4000, 32'h0001_0000};
    vt[9] = '{32'hFFFF_FFE7, 32'h0000_0005, 32'hFFFF_FFF1}; // -3*5, no cross carry

    // Reset state
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; s_in = 32'h0; c_in = 32'h0;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset product", product, 32'h0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MUL_CPA_STATS_EN
    check("reset done_cnt", {16'd0, done_cnt}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Backpressure: 6 back-to-back inputs, out_ready low for cycles 0..4
    sent = 0; got = 0; first_out = -1; last_out = -1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 5);
      in_valid  = (sent < 6);
      if (sent < 6) begin
        s_in = vt[sent].s;
        c_in = vt[sent].c;
      end else begin
        s_in = 32'h0;
        c_in = 32'h0;
      end
      @(negedge clk);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("bp spurious output", {31'd0, out_valid}, 32'd0);
        end else begin
          check("bp product order/hold", product, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            got++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(vt[sent].p);
        sent++;
      end
      if (cyc == 2) check("bp in_ready when full", {31'd0, in_ready}, 32'd0);
      if (cyc == 4) check("bp accepts during stall", sent, 32'd2);
    end
    in_valid = 1'b0;
    check("bp products out", got, 32'd6);
    check("bp first out cycle", first_out, 32'd5);
    check("bp one per cycle", last_out - first_out, 32'd5);
    check("bp queue empty", q.size(), 32'd0);
`ifdef MUL_CPA_STATS_EN
    check("bp done_cnt", {16'd0, done_cnt}, 32'd6);
`endif

    // Table vectors, one at a time
    for (int i = 0; i < 10; i++) begin
      apply_vec(vt[i], $sformatf("vec%0d", i));
    end

    // Reset mid-operation with both stages full
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; s_in = vt[6].s; c_in = vt[6].c;
    @(posedge clk); #1;
    s_in = vt[7].s; c_in = vt[7].c;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    check("pre-reset in_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-reset product", product, 32'h0);
    check("mid-reset in_ready", {31'd0, in_ready}, 32'd1);
`ifdef MUL_CPA_STATS_EN
    check("mid-reset done_cnt", {16'd0, done_cnt}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("post-reset idle", {31'd0, out_valid}, 32'd0);
    end
    apply_vec(vt[5], "post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_cpa_pipe.md
Name: mul_cpa_pipe

Overview:
- Final carry-propagate stage of the 16x16 two's-complement multiplier. It sits directly downstream of the 3:2 carry-save reduction.
- Consumes the last redundant pair: sum vector s and the unshifted carry vector c.
- Produces the 32-bit product as s + (c << 1) mod 2^32.
- Two-stage pipeline split at bit 16, with valid/ready handshakes on both sides and throughput of one product per cycle.

Parameters:
- PROD_W, 32, product and operand width.
- LO_W, 16, width of the low-half adder in stage 1; the high half is PROD_W-LO_W bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  s_in/c_in are valid.
- in_ready  output  1  block accepts in this cycle.
- s_in  input  PROD_W  CSA sum vector.
- c_in  input  PROD_W  CSA carry vector, unshifted (bit i has weight 2^(i+1)).
- out_valid  output  1  product is valid.
- out_ready  input  1  downstream accepts.
- product  output  PROD_W  s_in + (c_in << 1), truncated to PROD_W bits.

Behaviour:
- Shift: the internal operand is c_sh = {c_in[PROD_W-2:0], 1'b0}. c_in[PROD_W-1] is discarded by design (mod-2^32 arithmetic).
- Stage 1, on accept (in_valid & in_ready), registers:
  - lo_sum[LO_W-1:0] and lo_cout from s_in[LO_W-1:0] + c_sh[LO_W-1:0];
  - hi_s = s_in[PROD_W-1:LO_W] and hi_c = c_sh[PROD_W-1:LO_W];
  - sets v1.
- Stage 2, on advance, registers:
  - product[PROD_W-1:LO_W] = hi_s + hi_c + lo_cout (carry out discarded);
  - product[LO_W-1:0] = lo_sum;
  - sets v2.
- Latency: a product is valid 2 cycles after acceptance when unstalled.
- Handshake rules:
  - adv2 = v1 & (~v2 | out_ready).
  - in_ready = ~v1 | adv2 (combinational, no bubble).
  - out_valid = v2.
  - product is held stable while out_valid & ~out_ready.
- Register updates:
  - v2 clears on out_ready when there is no adv2.
  - v1 clears on adv2 when there is no new accept.
  - Simultaneous accept and adv2: v1 stays 1 with the new data loaded.
- Full condition: v1 & v2 & ~out_ready forces in_ready=0. At most 2 products are in flight, with no loss and no reordering.
- Empty condition: v1=v2=0 gives in_ready=1 and out_valid=0.
- Reset (async assert, any time, including mid-transfer):
  - v1=0, v2=0, out_valid=0, product=0, lo_sum/lo_cout/hi_s/hi_c=0;
  - in-flight data is dropped;
  - after deassertion, in_ready=1 and the block waits for in_valid.
- Inputs are sampled only on an accept cycle. Data registers update only on load, so there is no toggling while idle.

Optional Feature:
- Macro: MUL_CPA_STATS_EN.
- Defined:
  - adds output port done_cnt (16 bits);
  - it increments on each out_valid & out_ready, saturates at 16'hFFFF, and resets to 0.
- Undefined: no port, no counter logic. Functional behaviour is otherwise identical.

Decomposition:
- Package mul_tc_pkg holds:
  - localparams PROD_W=32 and LO_W=16;
  - typedef prod_t (logic [31:0]);
  - typedef half_t (logic [15:0]).
- The CSA stage shares this package.
- One natural sub-module: add_rca_16, a 16-bit ripple adder with cin/cout built from the existing full-adder cell. It is instantiated twice: stage-1 low half with cin=0, stage-2 high half with cin=lo_cout.

Test Plan:
- Basic add: s=32'h0000_0003, c=32'h0000_0002, out_ready=1 -> product=32'h0000_0007 exactly 2 cycles after accept.
- Cross-half carry: s=32'h0000_FFFF, c=32'h0000_0001 -> product=32'h0001_0001. Also s=32'hFFFF_FFF0, c=32'h0000_0008 -> product=32'h0000_0000 (wrap).
- Carry MSB drop: s=32'h0000_0000, c=32'h8000_0000 -> product=32'h0000_0000.
- Signed end-to-end: s/c pair from the CSA for -3*5 -> product=32'hFFFF_FFF1. Also 32767*-32768 -> 32'hC000_8000.
- Backpressure: stream 6 inputs back-to-back while out_ready=0 for 5 cycles ->
  - in_ready drops after 2 accepts;
  - product is held stable;
  - on release all 6 emerge in order with no duplicates;
  - 1 product/cycle while both sides are ready.
- Reset mid-operation: assert rst_n=0 with v1=v2=1 -> out_valid=0 and product=0 immediately. After release, in_ready=1 and the first new input's product appears 2 cycles after accept. With MUL_CPA_STATS_EN, done_cnt=0 after reset and reads 6 after the backpressure test.
